// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared types and helpers for the programmable clock-divider controller.
//   state_e   : controller states (idle, running, ratio change pending, draining)
//   MIN_HALF  : smallest legal half-period in clk cycles
//   sat_half  : maps a requested half-period of 0 onto MIN_HALF
// -----------------------------------------------------------------------------
package clk_div_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPend  = 2'd2,
        StDrain = 2'd3
    } state_e;

    localparam int unsigned MIN_HALF = 1;

    // A half-period of zero would never reach its terminal count; treat it as 1.
    function automatic logic [31:0] sat_half(input logic [31:0] h);
        return (h == 32'd0) ? 32'(MIN_HALF) : h;
    endfunction

endpackage

// File: rtl/clk_div_halfcnt.sv
// -----------------------------------------------------------------------------
// clk_div_halfcnt
// Half-period counter. Counts clk cycles while run is high and raises toggle in
// the cycle the count reaches half-1; the count then restarts from zero.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   run       : count enable (controller is in an active state)
//   clear     : force the count to zero on the next edge (wins over run)
//   half      : current half-period H (always >= 1)
//   toggle    : combinational strobe, the divided output flips on this edge
// -----------------------------------------------------------------------------
module clk_div_halfcnt
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             run,
    input  logic             clear,
    input  logic [CNT_W-1:0] half,
    output logic             toggle
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // half >= 1, so half-1 never underflows and the compare never wraps.
    assign toggle = run && (cnt_q == half - CNT_W'(MIN_HALF));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (toggle) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clk_div_sched.sv
// -----------------------------------------------------------------------------
// clk_div_sched
// Programmable clock-divider controller. Produces a registered 50% duty divided
// output with run-time configurable half-period H. New ratios are accepted via a
// valid/ready handshake and only take effect on a falling edge of div, so no
// runt pulses are produced. Stopping waits for the high phase to complete.
//
// Optional feature (define DIVCTRL_STATUS_EN):
//   period_cnt  : 16-bit count of div falling edges, wraps, reset to 0
//   cfg_applied : one-cycle pulse when a pending half-period takes effect
//
// Ports:
//   clk, rstn : system clock, asynchronous active-low reset
//   en        : level-sensitive run request
//   cfg_valid : new half-period offered on cfg_div
//   cfg_ready : controller can accept cfg_div (idle or running, nothing pending)
//   cfg_div   : requested half-period in clk cycles, 0 treated as 1
//   div       : divided output, period 2*H
//   tick      : pulse in every cycle in which div shows a new value
//   busy      : controller is running, has a change pending, or is draining
// -----------------------------------------------------------------------------
module clk_div_sched
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned RST_HALF = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             div,
    output logic             tick,
    output logic             busy
`ifdef DIVCTRL_STATUS_EN
    ,
    output logic [15:0]      period_cnt,
    output logic             cfg_applied
`endif
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pending_q, pending_d;
    logic             div_q, div_d;
    logic             tick_q;
    logic             apply_pend;

    logic             accept;
    logic [CNT_W-1:0] cfg_h;
    logic             toggle;
    logic             fall;
    logic             cnt_run;
    logic             cnt_clear;

    assign cfg_ready = (state_q == StIdle) || (state_q == StRun);
    assign accept    = cfg_valid && cfg_ready;
    assign cfg_h     = CNT_W'(sat_half(32'(cfg_div)));
    assign fall      = toggle && div_q;

    assign cnt_run   = (state_q != StIdle);
    // Any return to idle restarts the next run from a zero count.
    assign cnt_clear = (state_d == StIdle);

    clk_div_halfcnt #(
        .CNT_W (CNT_W)
    ) u_halfcnt (
        .clk    (clk),
        .rstn   (rstn),
        .run    (cnt_run),
        .clear  (cnt_clear),
        .half   (half_q),
        .toggle (toggle)
    );

    always_comb begin
        state_d    = state_q;
        half_d     = half_q;
        pend_d     = pend_q;
        pending_d  = pending_q;
        div_d      = div_q;
        apply_pend = 1'b0;

        unique case (state_q)
            StIdle: begin
                div_d = 1'b0;
                // Loaded immediately, so a start in the same cycle uses it.
                if (accept) begin
                    half_d = cfg_h;
                end
                if (en) begin
                    state_d = StRun;
                end
            end

            StRun, StPend, StDrain: begin
                if (toggle) begin
                    div_d = ~div_q;
                end
                // Only possible in StRun; cfg_ready is low elsewhere.
                if (accept) begin
                    pend_d    = cfg_h;
                    pending_d = 1'b1;
                end

                if (!en) begin
                    if (!div_q || fall) begin
                        // Low phase (suppress any rising toggle) or the high
                        // phase ends right now: stop without a runt.
                        state_d    = StIdle;
                        div_d      = 1'b0;
                        apply_pend = pending_d;
                    end else begin
                        state_d = StDrain;
                    end
                end else if (pending_q && fall) begin
                    // The old H finished its period; switch at this boundary.
                    apply_pend = 1'b1;
                    state_d    = StRun;
                end else if (pending_d) begin
                    state_d = StPend;
                end else begin
                    state_d = StRun;
                end
            end
        endcase

        if (apply_pend) begin
            half_d    = pend_d;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            half_q    <= CNT_W'(RST_HALF);
            pend_q    <= CNT_W'(RST_HALF);
            pending_q <= 1'b0;
            div_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            half_q    <= half_d;
            pend_q    <= pend_d;
            pending_q <= pending_d;
            div_q     <= div_d;
            tick_q    <= div_d ^ div_q;
        end
    end

    assign div  = div_q;
    assign tick = tick_q;
    assign busy = (state_q != StIdle);

`ifdef DIVCTRL_STATUS_EN
    logic [15:0] period_cnt_q;
    logic        cfg_applied_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            period_cnt_q  <= '0;
            cfg_applied_q <= 1'b0;
        end else begin
            if (div_q && !div_d) begin
                period_cnt_q <= period_cnt_q + 16'd1;
            end
            cfg_applied_q <= apply_pend;
        end
    end

    assign period_cnt  = period_cnt_q;
    assign cfg_applied = cfg_applied_q;
`endif

endmodule

// File: tb/tb_clk_div_sched.sv
// -----------------------------------------------------------------------------
// tb_clk_div_sched
// Directed and randomized stimulus for clk_div_sched, checked every cycle
// against a phase-level reference model (elapsed time in the current half
// phase, a queue of pending ratios, and run/drain flags).
// Optional outputs are checked when DIVCTRL_STATUS_EN is defined.
// -----------------------------------------------------------------------------
module tb_clk_div_sched;

    localparam int unsigned CNT_W    = 8;
    localparam int unsigned RST_HALF = 1;

    logic             clk = 1'b0;
    logic             rstn;
    logic             en;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_div;
    logic             div;
    logic             tick;
    logic             busy;
`ifdef DIVCTRL_STATUS_EN
    logic [15:0]      period_cnt;
    logic             cfg_applied;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    clk_div_sched #(
        .CNT_W    (CNT_W),
        .RST_HALF (RST_HALF)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .en          (en),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_div     (cfg_div),
        .div         (div),
        .tick        (tick),
        .busy        (busy)
`ifdef DIVCTRL_STATUS_EN
        ,
        .period_cnt  (period_cnt),
        .cfg_applied (cfg_applied)
`endif
    );

    // Reference model state.
    bit m_active;
    bit m_draining;
    bit m_div;
    bit m_tick;
    bit m_applied;
    int m_h;
    int m_elapsed;
    int m_periods;
    int m_pend[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active   = 1'b0;
        m_draining = 1'b0;
        m_div      = 1'b0;
        m_tick     = 1'b0;
        m_applied  = 1'b0;
        m_h        = RST_HALF;
        m_elapsed  = 0;
        m_periods  = 0;
        m_pend.delete();
    endtask

    function automatic bit m_ready();
        return !m_active || (!m_draining && m_pend.size() == 0);
    endfunction

    // One clock edge of the model, given the inputs sampled at that edge.
    task automatic model_edge(input bit e, input bit v, input int d);
        bit acc, had_pend, edge_now, falling, nd;
        int hreq;
        acc       = v && m_ready();
        hreq      = (d == 0) ? 1 : d;
        had_pend  = (m_pend.size() != 0);
        m_applied = 1'b0;
        if (!m_active) begin
            if (acc) m_h = hreq;
            nd        = 1'b0;
            m_elapsed = 0;
            if (e) begin
                m_active   = 1'b1;
                m_draining = 1'b0;
            end
        end else begin
            if (acc) m_pend.push_back(hreq);
            m_elapsed++;
            edge_now = (m_elapsed == m_h);
            if (edge_now) m_elapsed = 0;
            falling = edge_now && m_div;
            nd      = edge_now ? !m_div : m_div;
            if (!e) begin
                if (!m_div || falling) begin
                    m_active   = 1'b0;
                    m_draining = 1'b0;
                    nd         = 1'b0;
                    m_elapsed  = 0;
                    if (m_pend.size() != 0) begin
                        m_h       = m_pend.pop_front();
                        m_applied = 1'b1;
                    end
                end else begin
                    m_draining = 1'b1;
                end
            end else begin
                m_draining = 1'b0;
                if (falling && had_pend) begin
                    m_h       = m_pend.pop_front();
                    m_applied = 1'b1;
                end
            end
        end
        m_tick = (nd != m_div);
        if (m_div && !nd) m_periods = (m_periods + 1) % 65536;
        m_div = nd;
    endtask

    // Called at posedge+1: drive inputs, check ready mid-cycle, then outputs.
    task automatic step(input bit e, input bit v, input int d);
        en        = e;
        cfg_valid = v;
        cfg_div   = CNT_W'(d);
        @(negedge clk);
        check("cfg_ready", 32'(cfg_ready), 32'(m_ready()));
        @(posedge clk);
        model_edge(e, v, d);
        #1;
        check("div", 32'(div), 32'(m_div));
        check("tick", 32'(tick), 32'(m_tick));
        check("busy", 32'(busy), 32'(m_active));
`ifdef DIVCTRL_STATUS_EN
        check("period_cnt", 32'(period_cnt), 32'(m_periods));
        check("cfg_applied", 32'(cfg_applied), 32'(m_applied));
`endif
    endtask

    task automatic run_until(input bit e, input bit target, input int max);
        int n = 0;
        while (m_div != target && n < max) begin
            step(e, 1'b0, 0);
            n++;
        end
        check("run_until_div", 32'(div), 32'(target));
    endtask

    task automatic stop_idle(input int max);
        int n = 0;
        while (m_active && n < max) begin
            step(1'b0, 1'b0, 0);
            n++;
        end
        check("stop_idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rstn      = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_div", 32'(div), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        rstn = 1'b1;

        // H=1 from reset: first rise one cycle after entering RUN.
        step(1'b1, 1'b0, 0);
        check("h1_enter_div", 32'(div), 32'd0);
        step(1'b1, 1'b0, 0);
        check("h1_first_rise", 32'(div), 32'd1);
        repeat (18) step(1'b1, 1'b0, 0);

        // Load H=3 in idle, then run.
        stop_idle(10);
        step(1'b0, 1'b1, 3);
        repeat (14) step(1'b1, 1'b0, 0);

        // H=4 running; H=2 offered mid high phase.
        stop_idle(10);
        step(1'b0, 1'b1, 4);
        run_until(1'b1, 1'b1, 20);
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 2);
        check("pend_not_ready", 32'(cfg_ready), 32'd0);
        repeat (16) step(1'b1, 1'b0, 0);

        // H=5; drop en one cycle into the high phase, drain to idle.
        stop_idle(10);
        step(1'b0, 1'b1, 5);
        run_until(1'b1, 1'b1, 20);
        step(1'b0, 1'b0, 0);
        check("drain_div_high", 32'(div), 32'd1);
        stop_idle(10);
        // Rerun, and re-assert en within the drain.
        run_until(1'b1, 1'b1, 20);
        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 0);
        repeat (14) step(1'b1, 1'b0, 0);

        // cfg_div=0 is treated as H=1.
        stop_idle(10);
        step(1'b0, 1'b1, 0);
        repeat (8) step(1'b1, 1'b0, 0);

        // Reset in the middle of PEND discards the pending ratio.
        stop_idle(10);
        step(1'b0, 1'b1, 3);
        run_until(1'b1, 1'b1, 20);
        step(1'b1, 1'b1, 6);
        step(1'b1, 1'b0, 0);
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_div", 32'(div), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_cfg_ready", 32'(cfg_ready), 32'd1);
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (10) step(1'b1, 1'b0, 0);

        // Maximum half-period.
        stop_idle(10);
        step(1'b0, 1'b1, 255);
        run_until(1'b1, 1'b1, 300);
        run_until(1'b1, 1'b0, 300);
        stop_idle(300);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, $urandom_range(0, 5));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
